// File: rtl/core_bus_pkg.sv
// Shared types and constants for the core-to-Wishbone bus adapter.
package core_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } bus_state_t;

   localparam int DEFAULT_ADDR_W = 32;
   localparam int DEFAULT_DATA_W = 32;

   typedef struct packed {
      logic                          we;
      logic [DEFAULT_ADDR_W-1:0]     addr;
      logic [DEFAULT_DATA_W-1:0]     data;
      logic [DEFAULT_DATA_W/8-1:0]   sel;
   } req_t;

   // Width of an index into n items, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/core_bus_adapter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i wins.
module rr_arbiter
   import core_bus_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = idx_width(N)
)(
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] grant_idx_o
);

   localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

   // Scan the requesters in circular order starting from the pointer.
   always_comb begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] idx;
      logic             found;
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      sum         = '0;
      idx         = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
         if (sum >= N_W) begin
            sum = sum - N_W;
         end
         idx = sum[IDX_W-1:0];
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/core_bus_adapter.sv
// N-port core memory interface to Wishbone-classic master adapter.
// Each port owns a 1-deep request slot; slots are served round-robin, one
// bus cycle at a time. Optional bus watchdog enabled by macro BUS_TIMEOUT_EN.
module core_bus_adapter
   import core_bus_pkg::*;
#(
   parameter int NUM_PORTS      = 2,
   parameter int ADDR_W         = DEFAULT_ADDR_W,
   parameter int DATA_W         = DEFAULT_DATA_W,
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_PORTS-1:0]          req_en_i,
   output logic [NUM_PORTS-1:0]          req_ready_o,
   input  logic [NUM_PORTS-1:0]          req_we_i,
   input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr_i,
   input  logic [NUM_PORTS*DATA_W-1:0]   req_data_i,
   input  logic [NUM_PORTS*(DATA_W/8)-1:0] req_sel_i,
   output logic [NUM_PORTS-1:0]          rsp_valid_o,
   output logic [NUM_PORTS*DATA_W-1:0]   rsp_data_o,
   output logic [NUM_PORTS-1:0]          rsp_err_o,
   output logic                          wb_cyc_o,
   output logic                          wb_stb_o,
   output logic                          wb_we_o,
   output logic [ADDR_W-1:0]             wb_addr_o,
   output logic [DATA_W-1:0]             wb_data_o,
   output logic [DATA_W/8-1:0]           wb_sel_o,
   input  logic [DATA_W-1:0]             wb_data_i,
   input  logic                          wb_ack_i
);

   localparam int SEL_W = DATA_W / 8;
   localparam int IDX_W = idx_width(NUM_PORTS);

   if (NUM_PORTS < 1 || (DATA_W % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("core_bus_adapter: illegal parameter combination");
   end

   logic [NUM_PORTS-1:0]        pending_q, pending_d;
   logic [NUM_PORTS-1:0]        slot_we_q, slot_we_d;
   logic [NUM_PORTS*ADDR_W-1:0] slot_addr_q, slot_addr_d;
   logic [NUM_PORTS*DATA_W-1:0] slot_data_q, slot_data_d;
   logic [NUM_PORTS*SEL_W-1:0]  slot_sel_q, slot_sel_d;
   bus_state_t                  state_q, state_d;
   logic [IDX_W-1:0]            ptr_q, ptr_d;
   logic [IDX_W-1:0]            grant_idx_q, grant_idx_d;
   logic [NUM_PORTS-1:0]        grant_oh_q, grant_oh_d;
   logic                        wb_cyc_q, wb_cyc_d;
   logic                        wb_we_q, wb_we_d;
   logic [ADDR_W-1:0]           wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0]           wb_data_q, wb_data_d;
   logic [SEL_W-1:0]            wb_sel_q, wb_sel_d;
   logic [NUM_PORTS-1:0]        rsp_valid_q, rsp_valid_d;
   logic [NUM_PORTS*DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [NUM_PORTS-1:0]        arb_grant;
   logic [IDX_W-1:0]            arb_idx;
   logic                        bus_done;
   logic                        bus_err;

`ifdef BUS_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [NUM_PORTS-1:0]        rsp_err_q, rsp_err_d;
`endif

   rr_arbiter #(
      .N     (NUM_PORTS),
      .IDX_W (IDX_W)
   ) u_arb (
      .req_i       (pending_q),
      .ptr_i       (ptr_q),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx)
   );

   // Slot capture, bus FSM next state, response generation and watchdog.
   always_comb begin
      pending_d   = pending_q;
      slot_we_d   = slot_we_q;
      slot_addr_d = slot_addr_q;
      slot_data_d = slot_data_q;
      slot_sel_d  = slot_sel_q;
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_idx_d = grant_idx_q;
      grant_oh_d  = grant_oh_q;
      wb_cyc_d    = wb_cyc_q;
      wb_we_d     = wb_we_q;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
      wb_sel_d    = wb_sel_q;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      bus_done    = 1'b0;
      bus_err     = 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_d       = cnt_q;
      rsp_err_d   = rsp_err_q;
`endif

      for (int p = 0; p < NUM_PORTS; p++) begin
         if (req_en_i[p] && !pending_q[p]) begin
            pending_d[p]                      = 1'b1;
            slot_we_d[p]                      = req_we_i[p];
            slot_addr_d[p*ADDR_W +: ADDR_W]   = req_addr_i[p*ADDR_W +: ADDR_W];
            slot_data_d[p*DATA_W +: DATA_W]   = req_data_i[p*DATA_W +: DATA_W];
            slot_sel_d[p*SEL_W +: SEL_W]      = req_sel_i[p*SEL_W +: SEL_W];
         end
      end

      unique case (state_q)
         IDLE: begin
            if (|pending_q) begin
               grant_idx_d = arb_idx;
               grant_oh_d  = arb_grant;
               wb_cyc_d    = 1'b1;
               wb_we_d     = slot_we_q[arb_idx];
               wb_addr_d   = slot_addr_q[arb_idx*ADDR_W +: ADDR_W];
               wb_data_d   = slot_data_q[arb_idx*DATA_W +: DATA_W];
               wb_sel_d    = slot_sel_q[arb_idx*SEL_W +: SEL_W];
               state_d     = BUS;
`ifdef BUS_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         BUS: begin
            if (wb_ack_i) begin
               bus_done = 1'b1;
            end
`ifdef BUS_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               bus_done = 1'b1;
               bus_err  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
            if (bus_done) begin
               wb_cyc_d    = 1'b0;
               rsp_valid_d = grant_oh_q;
               pending_d   = pending_d & ~grant_oh_q;
               ptr_d       = (grant_idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx_q + 1'b1;
               state_d     = RESP;
               if (bus_err) begin
                  rsp_data_d[grant_idx_q*DATA_W +: DATA_W] = '0;
               end else if (!wb_we_q) begin
                  rsp_data_d[grant_idx_q*DATA_W +: DATA_W] = wb_data_i;
               end
`ifdef BUS_TIMEOUT_EN
               rsp_err_d[grant_idx_q] = bus_err;
`endif
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset drops the bus cycle and discards every request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q   <= '0;
         slot_we_q   <= '0;
         slot_addr_q <= '0;
         slot_data_q <= '0;
         slot_sel_q  <= '0;
         state_q     <= IDLE;
         ptr_q       <= '0;
         grant_idx_q <= '0;
         grant_oh_q  <= '0;
         wb_cyc_q    <= 1'b0;
         wb_we_q     <= 1'b0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
         wb_sel_q    <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
`ifdef BUS_TIMEOUT_EN
         cnt_q       <= '0;
         rsp_err_q   <= '0;
`endif
      end else begin
         pending_q   <= pending_d;
         slot_we_q   <= slot_we_d;
         slot_addr_q <= slot_addr_d;
         slot_data_q <= slot_data_d;
         slot_sel_q  <= slot_sel_d;
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_idx_q <= grant_idx_d;
         grant_oh_q  <= grant_oh_d;
         wb_cyc_q    <= wb_cyc_d;
         wb_we_q     <= wb_we_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
         wb_sel_q    <= wb_sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
`ifdef BUS_TIMEOUT_EN
         cnt_q       <= cnt_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign req_ready_o = ~pending_q;
   assign wb_cyc_o    = wb_cyc_q;
   assign wb_stb_o    = wb_cyc_q;
   assign wb_we_o     = wb_we_q;
   assign wb_addr_o   = wb_addr_q;
   assign wb_data_o   = wb_data_q;
   assign wb_sel_o    = wb_sel_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
`ifdef BUS_TIMEOUT_EN
   assign rsp_err_o   = rsp_err_q;
`else
   assign rsp_err_o   = '0;
`endif

endmodule

// File: tb/tb_core_bus_adapter.sv
// Self-checking bench for core_bus_adapter with a Wishbone slave model and
// scoreboard queues for expected bus cycles and per-port responses.
module tb_core_bus_adapter;
   import core_bus_pkg::*;

   localparam int NP = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic             clk;
   logic             rst_n;
   logic [NP-1:0]    req_en_i;
   logic [NP-1:0]    req_ready_o;
   logic [NP-1:0]    req_we_i;
   logic [NP*AW-1:0] req_addr_i;
   logic [NP*DW-1:0] req_data_i;
   logic [NP*4-1:0]  req_sel_i;
   logic [NP-1:0]    rsp_valid_o;
   logic [NP*DW-1:0] rsp_data_o;
   logic [NP-1:0]    rsp_err_o;
   logic             wb_cyc_o;
   logic             wb_stb_o;
   logic             wb_we_o;
   logic [AW-1:0]    wb_addr_o;
   logic [DW-1:0]    wb_data_o;
   logic [3:0]       wb_sel_o;
   logic [DW-1:0]    wb_data_i = '0;
   logic             wb_ack_i  = 1'b0;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } rsp_exp_t;

   typedef struct {
      int          port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
      int          delay;
      logic [31:0] expData;
   } vec_t;

   req_t     busQ[$];
   rsp_exp_t rspQ0[$];
   rsp_exp_t rspQ1[$];
   req_t     busExp;
   vec_t     vecs[7];

   int   nVectors     = 0;
   int   nMiscompares = 0;
   int   slvDelay     = 1;
   bit   slvNever     = 1'b0;
   int   slvWait      = 0;
   logic prevCyc      = 1'b0;

   core_bus_adapter #(
      .NUM_PORTS      (NP),
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_en_i    (req_en_i),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we_i),
      .req_addr_i  (req_addr_i),
      .req_data_i  (req_data_i),
      .req_sel_i   (req_sel_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_data_o  (rsp_data_o),
      .rsp_err_o   (rsp_err_o),
      .wb_cyc_o    (wb_cyc_o),
      .wb_stb_o    (wb_stb_o),
      .wb_we_o     (wb_we_o),
      .wb_addr_o   (wb_addr_o),
      .wb_data_o   (wb_data_o),
      .wb_sel_o    (wb_sel_o),
      .wb_data_i   (wb_data_i),
      .wb_ack_i    (wb_ack_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "[TB] simulation hung");
   end

   // Read data the slave returns for a given address.
   function automatic logic [31:0] memModel(input logic [31:0] a);
      if (a == 32'h100) return 32'hCAFEBABE;
      return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nVectors++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic popRsp(input int p);
      rsp_exp_t e;
      if ((p == 0 && rspQ0.size() == 0) || (p == 1 && rspQ1.size() == 0)) begin
         nVectors++;
         nMiscompares++;
         $display("[TB] FAIL unexpected_rsp%0d: got a response pulse, expected none", p);
      end else begin
         e = (p == 0) ? rspQ0.pop_front() : rspQ1.pop_front();
         checkOutput($sformatf("rsp%0d_data", p), 64'(rsp_data_o[p*32 +: 32]), 64'(e.data));
         checkOutput($sformatf("rsp%0d_err", p), 64'(rsp_err_o[p]), 64'(e.err));
      end
   endtask

   // Wishbone slave model plus bus-cycle and response monitors.
   always @(negedge clk) begin
      if (!rst_n) begin
         wb_ack_i = 1'b0;
         slvWait  = 0;
         prevCyc  = 1'b0;
      end else begin
         if (wb_cyc_o && !prevCyc) begin
            if (busQ.size() == 0) begin
               nVectors++;
               nMiscompares++;
               $display("[TB] FAIL unexpected_bus_cycle: got addr 0x%0h, expected no cycle", wb_addr_o);
            end else begin
               busExp = busQ.pop_front();
               checkOutput("wb_we_addr", 64'({wb_we_o, wb_addr_o}), 64'({busExp.we, busExp.addr}));
               checkOutput("wb_data_sel", 64'({wb_data_o, wb_sel_o}), 64'({busExp.data, busExp.sel}));
               checkOutput("wb_stb", 64'(wb_stb_o), 64'd1);
            end
         end
         prevCyc = wb_cyc_o;
         if (wb_cyc_o && !wb_ack_i) begin
            slvWait++;
            if (!slvNever && slvWait >= slvDelay) begin
               wb_ack_i  = 1'b1;
               wb_data_i = wb_we_o ? 32'hDEAD0000 : memModel(wb_addr_o);
               checkOutput("wb_hold_addr", 64'(wb_addr_o), 64'(busExp.addr));
            end
         end else begin
            wb_ack_i = 1'b0;
            slvWait  = 0;
         end
         for (int p = 0; p < NP; p++) begin
            if (rsp_valid_o[p]) popRsp(p);
         end
      end
   end

   task automatic pushExp(input int port, input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input logic [31:0] expData, input logic expErr, input bit pushRsp);
      req_t     b;
      rsp_exp_t r;
      b.we   = we;
      b.addr = addr;
      b.data = data;
      b.sel  = sel;
      busQ.push_back(b);
      if (pushRsp) begin
         r.data = expData;
         r.err  = expErr;
         if (port == 0) rspQ0.push_back(r);
         else           rspQ1.push_back(r);
      end
   endtask

   task automatic driveSlot(input int port, input logic we, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] sel);
      req_en_i[port]            = 1'b1;
      req_we_i[port]            = we;
      req_addr_i[port*32 +: 32] = addr;
      req_data_i[port*32 +: 32] = data;
      req_sel_i[port*4 +: 4]    = sel;
   endtask

   task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] sel, input logic [31:0] expData, input logic expErr,
                                input bit pushRsp);
      int n = 0;
      while (!req_ready_o[port] && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("ready_before_req", 64'(req_ready_o[port]), 64'd1);
      pushExp(port, we, addr, data, sel, expData, expErr, pushRsp);
      driveSlot(port, we, addr, data, sel);
      @(negedge clk);
      req_en_i = '0;
   endtask

   task automatic waitDrain(input string name, input int budget);
      int n = 0;
      while ((busQ.size() != 0 || rspQ0.size() != 0 || rspQ1.size() != 0 || wb_cyc_o) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 64'(busQ.size() + rspQ0.size() + rspQ1.size() + int'(wb_cyc_o)), 64'd0);
   endtask

   task automatic doReset();
      rst_n    = 1'b0;
      req_en_i = '0;
      #1;
      checkOutput("rst_ready", 64'(req_ready_o), 64'h3);
      checkOutput("rst_wb_ctrl", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
      checkOutput("rst_wb_addr", 64'(wb_addr_o), 64'd0);
      checkOutput("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      checkOutput("rst_rsp_data", 64'(rsp_data_o), 64'd0);
      checkOutput("rst_rsp_err", 64'(rsp_err_o), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      busQ.delete();
      rspQ0.delete();
      rspQ1.delete();
   endtask

   initial begin
      int n;
      req_en_i   = '0;
      req_we_i   = '0;
      req_addr_i = '0;
      req_data_i = '0;
      req_sel_i  = '0;
      doReset();

      // port, we, addr, wdata, sel, ack delay, expected response data
      vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0,         4'hF,    3, 32'hCAFEBABE};
      vecs[1] = '{1, 1'b1, 32'h0000_2000, 32'h12345678,  4'b0011, 2, 32'h0};
      vecs[2] = '{1, 1'b0, 32'h0000_2004, 32'h0,         4'hF,    1, memModel(32'h2004)};
      vecs[3] = '{0, 1'b1, 32'h0000_0104, 32'hA5A50F0F,  4'hF,    4, 32'hCAFEBABE};
      vecs[4] = '{0, 1'b0, 32'h0000_0108, 32'h0,         4'b0101, 0, memModel(32'h108)};
      vecs[5] = '{1, 1'b1, 32'hFFFF_FFFC, 32'hFFFFFFFF,  4'b1000, 1, memModel(32'h2004)};
      vecs[6] = '{1, 1'b0, 32'h0000_0000, 32'h0,         4'hF,    2, memModel(32'h0)};

      for (int i = 0; i < 7; i++) begin
         slvDelay = vecs[i].delay;
         applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel,
                       vecs[i].expData, 1'b0, 1'b1);
         waitDrain("drain_vec", 60);
      end

      // Simultaneous p0+p1 from a fresh pointer, twice in a row.
      doReset();
      slvDelay = 2;
      pushExp(0, 1'b0, 32'h800, 32'h0, 4'hF, memModel(32'h800), 1'b0, 1'b1);
      pushExp(1, 1'b1, 32'h900, 32'h0BADF00D, 4'b1100, 32'h0, 1'b0, 1'b1);
      driveSlot(0, 1'b0, 32'h800, 32'h0, 4'hF);
      driveSlot(1, 1'b1, 32'h900, 32'h0BADF00D, 4'b1100);
      @(negedge clk);
      req_en_i = '0;
      waitDrain("drain_burst1", 100);
      checkOutput("burst_ready", 64'(req_ready_o), 64'h3);
      pushExp(0, 1'b1, 32'hA00, 32'h11223344, 4'b0001, memModel(32'h800), 1'b0, 1'b1);
      pushExp(1, 1'b0, 32'hB00, 32'h0, 4'hF, memModel(32'hB00), 1'b0, 1'b1);
      driveSlot(0, 1'b1, 32'hA00, 32'h11223344, 4'b0001);
      driveSlot(1, 1'b0, 32'hB00, 32'h0, 4'hF);
      @(negedge clk);
      req_en_i = '0;
      waitDrain("drain_burst2", 100);

      // p0 re-requests during its own response while p1 waits: p1 must go next.
      doReset();
      slvDelay = 2;
      pushExp(0, 1'b0, 32'h500, 32'h0, 4'hF, memModel(32'h500), 1'b0, 1'b1);
      pushExp(1, 1'b0, 32'h600, 32'h0, 4'hF, memModel(32'h600), 1'b0, 1'b1);
      pushExp(0, 1'b0, 32'h700, 32'h0, 4'hF, memModel(32'h700), 1'b0, 1'b1);
      driveSlot(0, 1'b0, 32'h500, 32'h0, 4'hF);
      driveSlot(1, 1'b0, 32'h600, 32'h0, 4'hF);
      @(negedge clk);
      req_en_i = '0;
      n = 0;
      while (!rsp_valid_o[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("p0_rsp_seen", 64'(rsp_valid_o[0]), 64'd1);
      checkOutput("p0_ready_in_rsp", 64'(req_ready_o[0]), 64'd1);
      driveSlot(0, 1'b0, 32'h700, 32'h0, 4'hF);
      @(negedge clk);
      req_en_i = '0;
      waitDrain("drain_fairness", 100);

`ifdef BUS_TIMEOUT_EN
      // Slave never acks: watchdog aborts with an error response.
      slvNever = 1'b1;
      applyStimulus(0, 1'b0, 32'h300, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);
      n = 0;
      while (!wb_cyc_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (wb_cyc_o && n < 100) begin
         n++;
         @(negedge clk);
      end
      checkOutput("timeout_cycles", 64'(n), 64'(TO));
      slvNever = 1'b0;
      slvDelay = 1;
      applyStimulus(1, 1'b0, 32'h304, 32'h0, 4'hF, memModel(32'h304), 1'b0, 1'b1);
      waitDrain("drain_after_timeout", 60);
`endif

      // Reset in the middle of a bus cycle: cycle drops at once, no response.
      slvNever = 1'b1;
      applyStimulus(1, 1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
      n = 0;
      while (!wb_cyc_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rst_test_cyc_up", 64'(wb_cyc_o), 64'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async_cyc", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
      checkOutput("rst_async_ready", 64'(req_ready_o), 64'h3);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      busQ.delete();
      rspQ0.delete();
      rspQ1.delete();
      checkOutput("post_rst_ready", 64'(req_ready_o), 64'h3);
      repeat (10) @(negedge clk);
      checkOutput("post_rst_idle", 64'({wb_cyc_o, rsp_valid_o}), 64'd0);
      slvNever = 1'b0;
      slvDelay = 1;
      applyStimulus(1, 1'b0, 32'h404, 32'h0, 4'hF, memModel(32'h404), 1'b0, 1'b1);
      waitDrain("drain_after_reset", 60);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
